// File: rtl/bnn_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// bnn_seq_ctrl_if
// Host-side handshake bundle of the BNN sequencer.
//   cfg_*  : weight-programming byte stream (valid/ready/data[7:0])
//   inf_*  : inference input vector stream   (valid/ready/data[7:0])
//   res_*  : inference result stream         (valid/ready/data[3:0])
// master : host side (drives valids/data of cfg and inf, drives res_ready)
// slave  : sequencer side
// ---------------------------------------------------------------------------
interface bnn_seq_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_data;
    logic       inf_valid;
    logic       inf_ready;
    logic [7:0] inf_data;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;

    modport master (
        output cfg_valid, cfg_data, inf_valid, inf_data, res_ready,
        input  cfg_ready, inf_ready, res_valid, res_data
    );

    modport slave (
        input  cfg_valid, cfg_data, inf_valid, inf_data, res_ready,
        output cfg_ready, inf_ready, res_valid, res_data
    );
endinterface

// File: rtl/bnn_seq_ctrl.sv
// ---------------------------------------------------------------------------
// bnn_seq_ctrl
// Sequencer in front of the 8-8-4 BNN core. Arbitrates between the weight
// programming stream and the inference stream (weights win), splits each
// weight byte into a low/high nibble load pair, holds the input vector across
// the core pipeline and returns the 4-bit result over a valid/ready handshake.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   ena             global enable, 0 freezes all state and outputs
//   bus (slave)     cfg / inf / res handshakes (see bnn_seq_ctrl_if)
//   bnn_load_en     core load enable
//   bnn_weight_nib  core weight nibble
//   bnn_in          core input vector
//   bnn_out         core neuron outputs 3:0
//   load_cnt        weight bytes written since reset (saturates at NUM_NEURONS)
//   load_done       load_cnt == NUM_NEURONS
//   busy            FSM not in IDLE
//   cksum           weight checksum
//
// Optional feature macro: BNN_CKSUM_EN
//   defined   : cksum accumulates rotl(cksum) ^ byte on every high-nibble load
//   undefined : cksum is tied to 0
// ---------------------------------------------------------------------------
module bnn_seq_ctrl #(
    parameter int NUM_NEURONS = 12,
    parameter int PIPE_LAT    = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    bnn_seq_ctrl_if.slave    bus,
    output logic             bnn_load_en,
    output logic [3:0]       bnn_weight_nib,
    output logic [7:0]       bnn_in,
    input  logic [3:0]       bnn_out,
    output logic [CNT_W-1:0] load_cnt,
    output logic             load_done,
    output logic             busy,
    output logic [7:0]       cksum
);

    localparam int WAIT_W = $clog2(PIPE_LAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_LO,
        LOAD_HI,
        INF_WAIT,
        RESULT
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        byte_q, byte_d;
    logic [7:0]        bnn_in_q, bnn_in_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              res_valid_q, res_valid_d;
    logic [3:0]        res_data_q, res_data_d;
    logic              done;
    logic              cfg_hs;
    logic              inf_hs;

`ifdef BNN_CKSUM_EN
    logic [7:0]        cksum_q, cksum_d;
`endif

    assign done   = (cnt_q == CNT_W'(NUM_NEURONS));
    assign cfg_hs = bus.cfg_valid & bus.cfg_ready;
    assign inf_hs = bus.inf_valid & bus.inf_ready;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            byte_q      <= '0;
            bnn_in_q    <= '0;
            wait_q      <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
`ifdef BNN_CKSUM_EN
            cksum_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            bnn_in_q    <= bnn_in_d;
            wait_q      <= wait_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
`ifdef BNN_CKSUM_EN
            cksum_q     <= cksum_d;
`endif
        end
    end

    // Next-state and datapath update. Everything holds while ena is low; the
    // readies are also gated by ena so no handshake can slip through.
    // LOAD states are only entered while load_done is 0, so the counter
    // saturates at NUM_NEURONS without an explicit clamp.
    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        bnn_in_d    = bnn_in_q;
        wait_d      = wait_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
`ifdef BNN_CKSUM_EN
        cksum_d     = cksum_q;
`endif
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (cfg_hs) begin
                        byte_d  = bus.cfg_data;
                        state_d = LOAD_LO;
                    end else if (inf_hs) begin
                        bnn_in_d = bus.inf_data;
                        wait_d   = '0;
                        state_d  = INF_WAIT;
                    end
                end
                LOAD_LO: begin
                    state_d = LOAD_HI;
                end
                LOAD_HI: begin
                    cnt_d   = cnt_q + CNT_W'(1);
`ifdef BNN_CKSUM_EN
                    cksum_d = {cksum_q[6:0], cksum_q[7]} ^ byte_q;
`endif
                    state_d = IDLE;
                end
                INF_WAIT: begin
                    // bnn_in was registered on the handshake edge, so the core
                    // output reflects it once PIPE_LAT further edges have passed.
                    if (wait_q == WAIT_W'(PIPE_LAT)) begin
                        res_data_d  = bnn_out;
                        res_valid_d = 1'b1;
                        state_d     = RESULT;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        res_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output decode. The readies are forced low while reset is asserted so the
    // host never sees a ready during reset.
    always_comb begin
        bus.cfg_ready  = 1'b0;
        bus.inf_ready  = 1'b0;
        bnn_load_en    = 1'b0;
        bnn_weight_nib = 4'h0;
        busy           = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                bus.cfg_ready = ena & ~done & ~reset;
                bus.inf_ready = ena & ~(bus.cfg_valid & ~done) & ~reset;
            end
            LOAD_LO: begin
                bnn_load_en    = 1'b1;
                bnn_weight_nib = byte_q[3:0];
            end
            LOAD_HI: begin
                bnn_load_en    = 1'b1;
                bnn_weight_nib = byte_q[7:4];
            end
            default: begin
                bnn_load_en = 1'b0;
            end
        endcase
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bnn_in        = bnn_in_q;
    assign load_cnt      = cnt_q;
    assign load_done     = done;

`ifdef BNN_CKSUM_EN
    assign cksum = cksum_q;
`else
    assign cksum = 8'h00;
`endif

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bnn_seq_ctrl
// Self-checking bench for bnn_seq_ctrl: weight load table, inference table
// with a result scoreboard, plus hand-written arbitration, enable-freeze,
// back-pressure and mid-load reset sequences. The BNN core is modelled as a
// two-register pipeline computing in[7:4] ^ in[3:0] ^ 4'h4.
// ---------------------------------------------------------------------------
module tb_bnn_seq_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             ena;
    logic             bnn_load_en;
    logic [3:0]       bnn_weight_nib;
    logic [7:0]       bnn_in;
    logic [3:0]       bnn_out;
    logic [CNT_W-1:0] load_cnt;
    logic             load_done;
    logic             busy;
    logic [7:0]       cksum;

    logic [3:0]       core_s1;
    logic [3:0]       core_out;

    int               n_cmp = 0;
    int               n_err = 0;
    int               last_wait;
    logic [3:0]       exp_q[$];
    logic [7:0]       ck_exp;

    typedef struct {
        logic [7:0]       data;
        logic [3:0]       lo;
        logic [3:0]       hi;
        logic [CNT_W-1:0] cnt;
        logic             done;
    } load_vec_t;

    typedef struct {
        logic [7:0] data;
        logic [3:0] res;
    } inf_vec_t;

    load_vec_t load_tbl[12];
    inf_vec_t  inf_tbl[3];
    load_vec_t v;

    bnn_seq_ctrl_if bus();

    bnn_seq_ctrl #(
        .NUM_NEURONS (12),
        .PIPE_LAT    (2),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ena            (ena),
        .bus            (bus),
        .bnn_load_en    (bnn_load_en),
        .bnn_weight_nib (bnn_weight_nib),
        .bnn_in         (bnn_in),
        .bnn_out        (bnn_out),
        .load_cnt       (load_cnt),
        .load_done      (load_done),
        .busy           (busy),
        .cksum          (cksum)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] core_fn(input logic [7:0] x);
        return x[7:4] ^ x[3:0] ^ 4'h4;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            core_s1  <= 4'h0;
            core_out <= 4'h0;
        end else begin
            core_s1  <= core_fn(bnn_in);
            core_out <= core_s1;
        end
    end

    assign bnn_out = core_out;

    function automatic logic [7:0] ck_step(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = {c[6:0], c[7]} ^ b;
`ifndef BNN_CKSUM_EN
        r = 8'h00;
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst_load_en",   32'(bnn_load_en), 0);
        checkOutput("rst_nib",       32'(bnn_weight_nib), 0);
        checkOutput("rst_bnn_in",    32'(bnn_in), 0);
        checkOutput("rst_load_cnt",  32'(load_cnt), 0);
        checkOutput("rst_load_done", 32'(load_done), 0);
        checkOutput("rst_busy",      32'(busy), 0);
        checkOutput("rst_cksum",     32'(cksum), 0);
        checkOutput("rst_cfg_ready", 32'(bus.cfg_ready), 0);
        checkOutput("rst_inf_ready", 32'(bus.inf_ready), 0);
        checkOutput("rst_res_valid", 32'(bus.res_valid), 0);
        checkOutput("rst_res_data",  32'(bus.res_data), 0);
    endtask

    // One weight byte: handshake, low nibble, high nibble, back to IDLE.
    task automatic applyStimulus(input load_vec_t lv);
        int w;
        w = 0;
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = lv.data;
        #1;
        while (!bus.cfg_ready && w < 20) begin
            tick();
            w++;
        end
        checkOutput("cfg_ready_wait", 32'(bus.cfg_ready), 1);
        if (!bus.cfg_ready) begin
            bus.cfg_valid = 1'b0;
            return;
        end
        tick();
        bus.cfg_valid = 1'b0;
        checkOutput("lo_load_en", 32'(bnn_load_en), 1);
        checkOutput("lo_nib",     32'(bnn_weight_nib), 32'(lv.lo));
        tick();
        checkOutput("hi_load_en", 32'(bnn_load_en), 1);
        checkOutput("hi_nib",     32'(bnn_weight_nib), 32'(lv.hi));
        tick();
        checkOutput("idle_load_en", 32'(bnn_load_en), 0);
        checkOutput("load_cnt",     32'(load_cnt), 32'(lv.cnt));
        checkOutput("load_done",    32'(load_done), 32'(lv.done));
        ck_exp = ck_step(ck_exp, lv.data);
        checkOutput("cksum", 32'(cksum), 32'(ck_exp));
    endtask

    // One inference; hold = cycles res_ready stays low once res_valid is up.
    task automatic runInference(input logic [7:0] d, input logic [3:0] res, input int hold);
        int w;
        int lat;
        bus.res_ready = (hold == 0);
        bus.inf_valid = 1'b1;
        bus.inf_data  = d;
        #1;
        w = 0;
        while (!bus.inf_ready && w < 20) begin
            tick();
            w++;
        end
        last_wait = w;
        checkOutput("inf_ready_wait", 32'(bus.inf_ready), 1);
        if (!bus.inf_ready) begin
            bus.inf_valid = 1'b0;
            return;
        end
        tick();
        exp_q.push_back(res);
        bus.inf_valid = 1'b0;
        lat = 0;
        while (!bus.res_valid && lat < 20) begin
            checkOutput("bnn_in_hold", 32'(bnn_in), 32'(d));
            tick();
            lat++;
        end
        checkOutput("res_latency", 32'(lat), 3);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL scoreboard_empty: got result 0x%0h, expected none pending", bus.res_data);
        end else begin
            checkOutput("res_data", 32'(bus.res_data), 32'(exp_q.pop_front()));
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            checkOutput("bp_res_valid", 32'(bus.res_valid), 1);
            checkOutput("bp_res_data",  32'(bus.res_data), 32'(res));
            checkOutput("bp_inf_ready", 32'(bus.inf_ready), 0);
            checkOutput("bp_cfg_ready", 32'(bus.cfg_ready), 0);
        end
        bus.res_ready = 1'b1;
        tick();
        checkOutput("post_res_busy",  32'(busy), 0);
        checkOutput("post_res_valid", 32'(bus.res_valid), 0);
        checkOutput("post_res_bnn_in", 32'(bnn_in), 32'(d));
        bus.res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        load_tbl[0]  = '{8'h00, 4'h0, 4'h0, 4'd1,  1'b0};
        load_tbl[1]  = '{8'h01, 4'h1, 4'h0, 4'd2,  1'b0};
        load_tbl[2]  = '{8'h02, 4'h2, 4'h0, 4'd3,  1'b0};
        load_tbl[3]  = '{8'h03, 4'h3, 4'h0, 4'd4,  1'b0};
        load_tbl[4]  = '{8'h04, 4'h4, 4'h0, 4'd5,  1'b0};
        load_tbl[5]  = '{8'h05, 4'h5, 4'h0, 4'd6,  1'b0};
        load_tbl[6]  = '{8'h06, 4'h6, 4'h0, 4'd7,  1'b0};
        load_tbl[7]  = '{8'h07, 4'h7, 4'h0, 4'd8,  1'b0};
        load_tbl[8]  = '{8'h08, 4'h8, 4'h0, 4'd9,  1'b0};
        load_tbl[9]  = '{8'h09, 4'h9, 4'h0, 4'd10, 1'b0};
        load_tbl[10] = '{8'h0A, 4'hA, 4'h0, 4'd11, 1'b0};
        load_tbl[11] = '{8'h0B, 4'hB, 4'h0, 4'd12, 1'b1};
        inf_tbl[0]   = '{8'h12, 4'h7};
        inf_tbl[1]   = '{8'hFF, 4'h4};
        inf_tbl[2]   = '{8'h5A, 4'hB};

        reset         = 1'b1;
        ena           = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = 8'h00;
        bus.inf_valid = 1'b0;
        bus.inf_data  = 8'h00;
        bus.res_ready = 1'b0;
        ck_exp        = 8'h00;
        tick();
        tick();
        checkResetState();
        reset = 1'b0;
        #1;

        $display("[TB] loading 12 weight bytes");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(load_tbl[i]);
        end

        $display("[TB] 13th weight beat must stall");
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 8'hFF;
        #1;
        for (int i = 0; i < 6; i++) begin
            checkOutput("sat_cfg_ready", 32'(bus.cfg_ready), 0);
            checkOutput("sat_inf_ready", 32'(bus.inf_ready), 1);
            checkOutput("sat_load_en",   32'(bnn_load_en), 0);
            checkOutput("sat_load_cnt",  32'(load_cnt), 12);
            tick();
        end
        bus.cfg_valid = 1'b0;

        $display("[TB] inference 0xE0");
        runInference(8'hE0, 4'hA, 0);
        for (int i = 0; i < 3; i++) begin
            runInference(inf_tbl[i].data, inf_tbl[i].res, 0);
        end

        $display("[TB] result back-pressure");
        runInference(8'h81, 4'hD, 5);

        $display("[TB] reset, then simultaneous cfg and inf");
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        ck_exp = 8'h00;
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 8'hA5;
        bus.inf_valid = 1'b1;
        bus.inf_data  = 8'h3C;
        #1;
        checkOutput("arb_cfg_ready", 32'(bus.cfg_ready), 1);
        checkOutput("arb_inf_ready", 32'(bus.inf_ready), 0);
        tick();
        bus.cfg_valid = 1'b0;
        checkOutput("arb_lo_en",     32'(bnn_load_en), 1);
        checkOutput("arb_lo_nib",    32'(bnn_weight_nib), 32'h5);
        checkOutput("arb_lo_inf_rd", 32'(bus.inf_ready), 0);
        tick();
        checkOutput("arb_hi_nib",    32'(bnn_weight_nib), 32'hA);
        tick();
        checkOutput("arb_load_cnt",  32'(load_cnt), 1);
        ck_exp = ck_step(ck_exp, 8'hA5);
        checkOutput("arb_cksum",     32'(cksum), 32'(ck_exp));
        runInference(8'h3C, 4'hB, 0);
        checkOutput("arb_inf_wait",  32'(last_wait), 0);

        $display("[TB] enable freeze in IDLE and LOAD_HI");
        ena = 1'b0;
        #1;
        checkOutput("frz_idle_cfg_ready", 32'(bus.cfg_ready), 0);
        checkOutput("frz_idle_inf_ready", 32'(bus.inf_ready), 0);
        ena = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 8'h7E;
        #1;
        checkOutput("frz_cfg_ready", 32'(bus.cfg_ready), 1);
        tick();
        bus.cfg_valid = 1'b0;
        tick();
        checkOutput("frz_hi_en",  32'(bnn_load_en), 1);
        checkOutput("frz_hi_nib", 32'(bnn_weight_nib), 32'h7);
        ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("frz_load_en",  32'(bnn_load_en), 1);
            checkOutput("frz_nib",      32'(bnn_weight_nib), 32'h7);
            checkOutput("frz_load_cnt", 32'(load_cnt), 1);
            checkOutput("frz_busy",     32'(busy), 1);
        end
        ena = 1'b1;
        tick();
        checkOutput("frz_cnt_after", 32'(load_cnt), 2);
        checkOutput("frz_en_after",  32'(bnn_load_en), 0);
        checkOutput("frz_busy_after", 32'(busy), 0);
        ck_exp = ck_step(ck_exp, 8'h7E);
        checkOutput("frz_cksum", 32'(cksum), 32'(ck_exp));
        tick();
        checkOutput("frz_cnt_once", 32'(load_cnt), 2);

        $display("[TB] reset during LOAD_LO of byte 5");
        v = '{8'h11, 4'h1, 4'h1, 4'd3, 1'b0};
        applyStimulus(v);
        v = '{8'h22, 4'h2, 4'h2, 4'd4, 1'b0};
        applyStimulus(v);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 8'h33;
        #1;
        tick();
        bus.cfg_valid = 1'b0;
        checkOutput("b5_lo_en", 32'(bnn_load_en), 1);
        reset = 1'b1;
        tick();
        checkResetState();
        reset  = 1'b0;
        ck_exp = 8'h00;
        exp_q.delete();
        #1;
        v = '{8'h01, 4'h1, 4'h0, 4'd1, 1'b0};
        applyStimulus(v);
        v = '{8'h02, 4'h2, 4'h0, 4'd2, 1'b0};
        applyStimulus(v);
        checkOutput("cksum_final", 32'(cksum), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
